// File: rtl/spi_pkg.sv
// Shared types and default sizes for the SPI serial-clock generator.
package spi_pkg;

  // Two-state controller: waiting for a request, or producing SCK.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int DEF_DIV_WIDTH = 16;
  localparam int DEF_CNT_WIDTH = 6;

  // Half-period substituted when a zero divisor is requested.
  localparam logic [DEF_DIV_WIDTH-1:0] DEF_HALF = 16'd7;

endpackage

// File: rtl/spi_sclk_gen_half_counter.sv
// Half-period counter: counts clock_in cycles within one SCK half-period and
// raises a combinational tick on the last cycle of each half-period.
module sclk_half_counter
  import spi_pkg::*;
#(
  parameter int DIV_WIDTH = DEF_DIV_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 en_i,
  input  logic [DIV_WIDTH-1:0] half_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] hc_q;
  logic [DIV_WIDTH-1:0] hc_d;

  // half_i is never zero here, so half_i-1 cannot underflow.
  assign tick_o = en_i && (hc_q == (half_i - DIV_WIDTH'(1)));

  // Next count: wraps to zero on the terminal tick, held at zero when cleared.
  always_comb begin
    hc_d = hc_q;
    if (clear_i) begin
      hc_d = '0;
    end else if (en_i) begin
      if (tick_o) begin
        hc_d = '0;
      end else begin
        hc_d = hc_q + DIV_WIDTH'(1);
      end
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hc_q <= '0;
    end else begin
      hc_q <= hc_d;
    end
  end

endmodule

// File: rtl/spi_sclk_gen.sv
// Programmable SPI serial-clock generator. Emits a burst of N SCK cycles (or a
// free-running SCK) with selectable idle polarity, plus single-cycle strobes
// aligned with the leading and trailing SCK transitions so SPI shift registers
// can run entirely in the clock_in domain.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int                   DIV_WIDTH    = DEF_DIV_WIDTH,
  parameter int                   CNT_WIDTH    = DEF_CNT_WIDTH,
  parameter logic [DIV_WIDTH-1:0] DEFAULT_HALF = DIV_WIDTH'(DEF_HALF)
) (
  input  logic                 clock_in,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 free_run,
  input  logic                 abort,
  input  logic [DIV_WIDTH-1:0] div_half,
  input  logic [CNT_WIDTH-1:0] num_cycles,
  input  logic                 cpol,
  output logic                 sclk,
  output logic                 lead_edge,
  output logic                 trail_edge,
  output logic                 busy,
  output logic                 done
);

  state_e               state_q;
  state_e               state_d;

  // Configuration captured when a request is accepted.
  logic [DIV_WIDTH-1:0] half_q;
  logic [DIV_WIDTH-1:0] half_d;
  logic [CNT_WIDTH-1:0] ncyc_q;
  logic [CNT_WIDTH-1:0] ncyc_d;
  logic                 cpol_q;
  logic                 cpol_d;
  logic                 free_q;
  logic                 free_d;

  // Completed SCK cycles in the current burst.
  logic [CNT_WIDTH-1:0] cc_q;
  logic [CNT_WIDTH-1:0] cc_d;
  logic [CNT_WIDTH-1:0] cc_inc;

  // Registered outputs.
  logic                 sclk_q;
  logic                 sclk_d;
  logic                 lead_q;
  logic                 lead_d;
  logic                 trail_q;
  logic                 trail_d;
  logic                 busy_q;
  logic                 busy_d;
  logic                 done_q;
  logic                 done_d;

  logic                 tick;
  logic                 is_lead;
  logic                 is_trail;
  logic                 burst_end;
  logic                 zero_burst;

  // A zero divisor would stall the counter, so it maps to a safe default.
  function automatic logic [DIV_WIDTH-1:0] eff_half(input logic [DIV_WIDTH-1:0] d);
    return (d == '0) ? DEFAULT_HALF : d;
  endfunction

  sclk_half_counter #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_half_counter (
    .clk_i   (clock_in),
    .rst_i   (reset),
    .clear_i (state_q == IDLE),
    .en_i    (state_q == RUN),
    .half_i  (half_q),
    .tick_o  (tick)
  );

  // A toggle away from the idle level is a lead edge; back to idle is a trail.
  assign is_lead    = tick && (sclk_q == cpol_q);
  assign is_trail   = tick && (sclk_q != cpol_q);
  assign cc_inc     = cc_q + CNT_WIDTH'(1);
  assign burst_end  = is_trail && !free_q && (cc_inc == ncyc_q);
  assign zero_burst = !free_run && (num_cycles == '0);

  // State register plus all registered outputs and captured configuration.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q <= IDLE;
      half_q  <= '0;
      ncyc_q  <= '0;
      cpol_q  <= 1'b0;
      free_q  <= 1'b0;
      cc_q    <= '0;
      sclk_q  <= 1'b0;
      lead_q  <= 1'b0;
      trail_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      ncyc_q  <= ncyc_d;
      cpol_q  <= cpol_d;
      free_q  <= free_d;
      cc_q    <= cc_d;
      sclk_q  <= sclk_d;
      lead_q  <= lead_d;
      trail_q <= trail_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state: leave IDLE on a non-empty request; abort takes precedence over
  // the final trail edge when returning to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start && !zero_burst) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort || burst_end) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values for each state.
  always_comb begin
    sclk_d  = sclk_q;
    lead_d  = 1'b0;
    trail_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cc_d    = cc_q;
    half_d  = half_q;
    ncyc_d  = ncyc_q;
    cpol_d  = cpol_q;
    free_d  = free_q;
    case (state_q)
      IDLE: begin
        // SCK follows the requested polarity while idle.
        sclk_d = cpol;
        busy_d = 1'b0;
        if (start) begin
          half_d = eff_half(div_half);
          ncyc_d = num_cycles;
          cpol_d = cpol;
          free_d = free_run;
          cc_d   = '0;
          if (zero_burst) begin
            done_d = 1'b1;
          end else begin
            busy_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          // Snap back to idle level silently; an interrupted burst never
          // reports completion.
          sclk_d = cpol_q;
          busy_d = 1'b0;
        end else if (tick) begin
          sclk_d  = ~sclk_q;
          lead_d  = is_lead;
          trail_d = is_trail;
          if (is_trail && !free_q) begin
            cc_d = cc_inc;
          end
          if (burst_end) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign sclk       = sclk_q;
  assign lead_edge  = lead_q;
  assign trail_edge = trail_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
